// File: rtl/arm_pkg.sv
// Shared definitions for the 5-stage ARM core pipeline.
// Contents: datapath width constants, EXE command encodings, the ID->EXE
// control vector type, its bubble value, and the valid-gating helper.
package arm_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned RADDR_W = 4;
    localparam int unsigned CMD_W   = 4;

    localparam logic [3:0] EXE_CMD_MOV = 4'b0001;
    localparam logic [3:0] EXE_CMD_MVN = 4'b1001;
    localparam logic [3:0] EXE_CMD_ADD = 4'b0010;
    localparam logic [3:0] EXE_CMD_ADC = 4'b0011;
    localparam logic [3:0] EXE_CMD_SUB = 4'b0100;
    localparam logic [3:0] EXE_CMD_SBC = 4'b0101;
    localparam logic [3:0] EXE_CMD_AND = 4'b0110;
    localparam logic [3:0] EXE_CMD_ORR = 4'b0111;
    localparam logic [3:0] EXE_CMD_EOR = 4'b1000;
    localparam logic [3:0] EXE_CMD_CMP = 4'b0100;
    localparam logic [3:0] EXE_CMD_TST = 4'b0110;
    localparam logic [3:0] EXE_CMD_LDR = 4'b0010;
    localparam logic [3:0] EXE_CMD_STR = 4'b0010;

    // Control bits that cause architectural side effects in later stages.
    typedef struct packed {
        logic valid;
        logic wb_en;
        logic mem_r_en;
        logic mem_w_en;
        logic b;
        logic s;
        logic or_out;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // An invalid slot must never write back, touch memory, branch or update SR,
    // so every side-effect bit is qualified by valid here.
    function automatic ctrl_t gate_ctrl(
        input logic valid,
        input logic wb_en,
        input logic mem_r_en,
        input logic mem_w_en,
        input logic b,
        input logic s
    );
        ctrl_t c;
        c.valid    = valid;
        c.wb_en    = wb_en & valid;
        c.mem_r_en = mem_r_en & valid;
        c.mem_w_en = mem_w_en & valid;
        c.b        = b & valid;
        c.s        = s & valid;
        c.or_out   = (mem_r_en | mem_w_en) & valid;
        return c;
    endfunction

endpackage

// File: rtl/pipe_reg_ce.sv
// Generic pipeline register slice.
// Ports: clk, rst_n (async active-low clear), clr (sync clear, beats en),
//        en (load d when set, otherwise hold), d in, q out (W bits).
module pipe_reg_ce #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = '0;
        end else if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/id_exe_pipe_reg.sv
// ID->EXE pipeline register of the 5-stage ARM core.
// Captures the decoded instruction at the end of ID and presents it to EXE.
// Ports: clk, rst_n (async active-low), flush (bubble, highest priority),
//        freeze (hold), id_* decoded fields in, exe_* registered copies out,
//        exe_or_out = registered memory-access flag (load or store).
// All outputs come straight from flops; there is no input-to-output path.
module id_exe_pipe_reg
    import arm_pkg::*;
#(
    parameter int unsigned DATA_W  = arm_pkg::DATA_W,
    parameter int unsigned RADDR_W = arm_pkg::RADDR_W,
    parameter int unsigned CMD_W   = arm_pkg::CMD_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               freeze,
    input  logic               id_valid,
    input  logic [DATA_W-1:0]  id_pc,
    input  logic               id_wb_en,
    input  logic               id_mem_r_en,
    input  logic               id_mem_w_en,
    input  logic [CMD_W-1:0]   id_exe_cmd,
    input  logic               id_b,
    input  logic               id_s,
    input  logic               id_imm,
    input  logic [11:0]        id_shift_operand,
    input  logic [23:0]        id_imm24,
    input  logic [DATA_W-1:0]  id_val_rn,
    input  logic [DATA_W-1:0]  id_val_rm,
    input  logic [RADDR_W-1:0] id_dest,
    input  logic [RADDR_W-1:0] id_src1,
    input  logic [RADDR_W-1:0] id_src2,
    input  logic [3:0]         id_sr,
    output logic               exe_valid,
    output logic [DATA_W-1:0]  exe_pc,
    output logic               exe_wb_en,
    output logic               exe_mem_r_en,
    output logic               exe_mem_w_en,
    output logic [CMD_W-1:0]   exe_exe_cmd,
    output logic               exe_b,
    output logic               exe_s,
    output logic               exe_imm,
    output logic [11:0]        exe_shift_operand,
    output logic [23:0]        exe_imm24,
    output logic [DATA_W-1:0]  exe_val_rn,
    output logic [DATA_W-1:0]  exe_val_rm,
    output logic [RADDR_W-1:0] exe_dest,
    output logic [RADDR_W-1:0] exe_src1,
    output logic [RADDR_W-1:0] exe_src2,
    output logic [3:0]         exe_sr,
    output logic               exe_or_out
);

    localparam int unsigned CTRL_W = $bits(ctrl_t);
    localparam int unsigned OPND_W = 3 * DATA_W + 12 + 24;
    localparam int unsigned IDX_W  = CMD_W + 3 * RADDR_W + 1 + 4;

    logic load_en;
    assign load_en = !freeze;

    // Control group: valid-gated side-effect bits.
    ctrl_t ctrl_in;
    ctrl_t ctrl_out;

    always_comb begin
        ctrl_in = gate_ctrl(id_valid, id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s);
    end

    pipe_reg_ce #(.W(CTRL_W)) u_ctrl_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .en    (load_en),
        .d     (ctrl_in),
        .q     (ctrl_out)
    );

    assign exe_valid    = ctrl_out.valid;
    assign exe_wb_en    = ctrl_out.wb_en;
    assign exe_mem_r_en = ctrl_out.mem_r_en;
    assign exe_mem_w_en = ctrl_out.mem_w_en;
    assign exe_b        = ctrl_out.b;
    assign exe_s        = ctrl_out.s;
    assign exe_or_out   = ctrl_out.or_out;

    // Operand group: loads even for invalid slots.
    logic [OPND_W-1:0] opnd_in;
    logic [OPND_W-1:0] opnd_out;

    assign opnd_in = {id_pc, id_val_rn, id_val_rm, id_shift_operand, id_imm24};

    pipe_reg_ce #(.W(OPND_W)) u_opnd_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .en    (load_en),
        .d     (opnd_in),
        .q     (opnd_out)
    );

    assign {exe_pc, exe_val_rn, exe_val_rm, exe_shift_operand, exe_imm24} = opnd_out;

    // Index / command / flag group.
    logic [IDX_W-1:0] idx_in;
    logic [IDX_W-1:0] idx_out;

    assign idx_in = {id_exe_cmd, id_dest, id_src1, id_src2, id_imm, id_sr};

    pipe_reg_ce #(.W(IDX_W)) u_idx_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .en    (load_en),
        .d     (idx_in),
        .q     (idx_out)
    );

    assign {exe_exe_cmd, exe_dest, exe_src1, exe_src2, exe_imm, exe_sr} = idx_out;

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Self-checking bench for id_exe_pipe_reg: directed vector table, hand-written
// reset/freeze sequences and a randomized stream against a reference model.
module tb_id_exe_pipe_reg;

    typedef struct packed {
        logic        flush;
        logic        freeze;
        logic        valid;
        logic        wb_en;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        b;
        logic        s;
        logic [31:0] pc;
        logic [3:0]  cmd;
        logic        imm;
        logic [11:0] shift;
        logic [23:0] imm24;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [3:0]  sr;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic        wb_en;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        b;
        logic        s;
        logic        or_out;
        logic [31:0] pc;
        logic [3:0]  cmd;
        logic        imm;
        logic [11:0] shift;
        logic [23:0] imm24;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [3:0]  sr;
    } out_t;

    // Key fields checked by the directed table.
    typedef struct packed {
        logic        valid;
        logic        wb_en;
        logic        mem_w_en;
        logic        b;
        logic        s;
        logic        or_out;
        logic        imm;
        logic [11:0] shift;
        logic [3:0]  cmd;
        logic [31:0] rn;
        logic [31:0] rm;
    } key_t;

    typedef struct {
        string nm;
        in_t   in;
        key_t  exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        flush, freeze, id_valid, id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s, id_imm;
    logic [31:0] id_pc, id_val_rn, id_val_rm;
    logic [3:0]  id_exe_cmd, id_dest, id_src1, id_src2, id_sr;
    logic [11:0] id_shift_operand;
    logic [23:0] id_imm24;
    logic        exe_valid, exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_b, exe_s, exe_imm, exe_or_out;
    logic [31:0] exe_pc, exe_val_rn, exe_val_rm;
    logic [3:0]  exe_exe_cmd, exe_dest, exe_src1, exe_src2, exe_sr;
    logic [11:0] exe_shift_operand;
    logic [23:0] exe_imm24;

    int unsigned errors = 0;
    int unsigned checks = 0;
    out_t        model;
    out_t        act;
    key_t        got_k;

    id_exe_pipe_reg #(.DATA_W(32), .RADDR_W(4), .CMD_W(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush             (flush),
        .freeze            (freeze),
        .id_valid          (id_valid),
        .id_pc             (id_pc),
        .id_wb_en          (id_wb_en),
        .id_mem_r_en       (id_mem_r_en),
        .id_mem_w_en       (id_mem_w_en),
        .id_exe_cmd        (id_exe_cmd),
        .id_b              (id_b),
        .id_s              (id_s),
        .id_imm            (id_imm),
        .id_shift_operand  (id_shift_operand),
        .id_imm24          (id_imm24),
        .id_val_rn         (id_val_rn),
        .id_val_rm         (id_val_rm),
        .id_dest           (id_dest),
        .id_src1           (id_src1),
        .id_src2           (id_src2),
        .id_sr             (id_sr),
        .exe_valid         (exe_valid),
        .exe_pc            (exe_pc),
        .exe_wb_en         (exe_wb_en),
        .exe_mem_r_en      (exe_mem_r_en),
        .exe_mem_w_en      (exe_mem_w_en),
        .exe_exe_cmd       (exe_exe_cmd),
        .exe_b             (exe_b),
        .exe_s             (exe_s),
        .exe_imm           (exe_imm),
        .exe_shift_operand (exe_shift_operand),
        .exe_imm24         (exe_imm24),
        .exe_val_rn        (exe_val_rn),
        .exe_val_rm        (exe_val_rm),
        .exe_dest          (exe_dest),
        .exe_src1          (exe_src1),
        .exe_src2          (exe_src2),
        .exe_sr            (exe_sr),
        .exe_or_out        (exe_or_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign act = {exe_valid, exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_b, exe_s, exe_or_out,
                  exe_pc, exe_exe_cmd, exe_imm, exe_shift_operand, exe_imm24,
                  exe_val_rn, exe_val_rm, exe_dest, exe_src1, exe_src2, exe_sr};

    assign got_k = {exe_valid, exe_wb_en, exe_mem_w_en, exe_b, exe_s, exe_or_out,
                    exe_imm, exe_shift_operand, exe_exe_cmd, exe_val_rn, exe_val_rm};

    // Reference rules: flush clears everything, freeze holds, otherwise load
    // with side-effect bits qualified by valid.
    function automatic out_t model_next(input out_t cur, input in_t i);
        out_t n;
        if (i.flush) begin
            n = '0;
        end else if (i.freeze) begin
            n = cur;
        end else begin
            n.valid    = i.valid;
            n.wb_en    = i.wb_en && i.valid;
            n.mem_r_en = i.mem_r_en && i.valid;
            n.mem_w_en = i.mem_w_en && i.valid;
            n.b        = i.b && i.valid;
            n.s        = i.s && i.valid;
            n.or_out   = (i.mem_r_en || i.mem_w_en) && i.valid;
            n.pc       = i.pc;
            n.cmd      = i.cmd;
            n.imm      = i.imm;
            n.shift    = i.shift;
            n.imm24    = i.imm24;
            n.rn       = i.rn;
            n.rm       = i.rm;
            n.dest     = i.dest;
            n.src1     = i.src1;
            n.src2     = i.src2;
            n.sr       = i.sr;
        end
        return n;
    endfunction

    function automatic in_t rand_in();
        in_t i;
        i.flush    = ($urandom_range(0, 9) == 0);
        i.freeze   = ($urandom_range(0, 4) == 0);
        i.valid    = ($urandom_range(0, 3) != 0);
        i.wb_en    = 1'($urandom);
        i.mem_r_en = 1'($urandom);
        i.mem_w_en = 1'($urandom);
        i.b        = 1'($urandom);
        i.s        = 1'($urandom);
        i.pc       = $urandom;
        i.cmd      = 4'($urandom);
        i.imm      = 1'($urandom);
        i.shift    = 12'($urandom);
        i.imm24    = 24'($urandom);
        i.rn       = $urandom;
        i.rm       = $urandom;
        i.dest     = 4'($urandom);
        i.src1     = 4'($urandom);
        i.src2     = 4'($urandom);
        i.sr       = 4'($urandom);
        return i;
    endfunction

    task automatic drive(input in_t i);
        flush            = i.flush;
        freeze           = i.freeze;
        id_valid         = i.valid;
        id_wb_en         = i.wb_en;
        id_mem_r_en      = i.mem_r_en;
        id_mem_w_en      = i.mem_w_en;
        id_b             = i.b;
        id_s             = i.s;
        id_pc            = i.pc;
        id_exe_cmd       = i.cmd;
        id_imm           = i.imm;
        id_shift_operand = i.shift;
        id_imm24         = i.imm24;
        id_val_rn        = i.rn;
        id_val_rm        = i.rm;
        id_dest          = i.dest;
        id_src1          = i.src1;
        id_src2          = i.src2;
        id_sr            = i.sr;
    endtask

    task automatic check_full(input string nm);
        checks++;
        if (act !== model) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, model);
        end
    endtask

    // Drive, clock once, advance the model, then sample 1 time unit after the edge.
    task automatic step(input in_t i, input string nm);
        drive(i);
        @(posedge clk);
        model = model_next(model, i);
        #1;
        check_full(nm);
    endtask

    vec_t vecs[6];

    initial begin
        in_t  z;
        in_t  ri;
        out_t saved;

        z = '0;
        drive(z);
        rst_n = 1'b0;
        model = '0;
        #1;
        check_full("reset_at_time0");
        @(posedge clk);
        #1;
        check_full("reset_held_over_edge");
        rst_n = 1'b1;

        // Directed table.
        vecs[0].nm = "add_r1_r2_imm";
        vecs[0].in = '0;
        vecs[0].in.valid = 1'b1; vecs[0].in.wb_en = 1'b1; vecs[0].in.imm = 1'b1;
        vecs[0].in.shift = 12'h0FF; vecs[0].in.cmd = 4'b0010;
        vecs[0].in.rn = 32'h11; vecs[0].in.dest = 4'd1; vecs[0].in.src1 = 4'd2;
        vecs[0].exp = '{valid: 1'b1, wb_en: 1'b1, mem_w_en: 1'b0, b: 1'b0, s: 1'b0, or_out: 1'b0,
                        imm: 1'b1, shift: 12'h0FF, cmd: 4'b0010, rn: 32'h11, rm: 32'h0};

        vecs[1].nm = "str_load";
        vecs[1].in = '0;
        vecs[1].in.valid = 1'b1; vecs[1].in.mem_w_en = 1'b1; vecs[1].in.cmd = 4'b0010;
        vecs[1].in.rn = 32'h100; vecs[1].in.rm = 32'hCAFE;
        vecs[1].exp = '{valid: 1'b1, wb_en: 1'b0, mem_w_en: 1'b1, b: 1'b0, s: 1'b0, or_out: 1'b1,
                        imm: 1'b0, shift: 12'h0, cmd: 4'b0010, rn: 32'h100, rm: 32'hCAFE};

        vecs[2].nm = "flush_beats_freeze_str";
        vecs[2].in = vecs[1].in;
        vecs[2].in.flush = 1'b1; vecs[2].in.freeze = 1'b1; vecs[2].in.rm = 32'h1234;
        vecs[2].exp = '0;

        vecs[3].nm = "invalid_gates_ctrl";
        vecs[3].in = '0;
        vecs[3].in.valid = 1'b0; vecs[3].in.wb_en = 1'b1; vecs[3].in.b = 1'b1;
        vecs[3].in.rn = 32'hDEADBEEF; vecs[3].in.rm = 32'h5; vecs[3].in.cmd = 4'b0001;
        vecs[3].exp = '{valid: 1'b0, wb_en: 1'b0, mem_w_en: 1'b0, b: 1'b0, s: 1'b0, or_out: 1'b0,
                        imm: 1'b0, shift: 12'h0, cmd: 4'b0001, rn: 32'hDEADBEEF, rm: 32'h5};

        vecs[4].nm = "sub_sets_s";
        vecs[4].in = '0;
        vecs[4].in.valid = 1'b1; vecs[4].in.s = 1'b1; vecs[4].in.cmd = 4'b0100;
        vecs[4].in.rn = 32'h7; vecs[4].in.shift = 12'hA5A;
        vecs[4].exp = '{valid: 1'b1, wb_en: 1'b0, mem_w_en: 1'b0, b: 1'b0, s: 1'b1, or_out: 1'b0,
                        imm: 1'b0, shift: 12'hA5A, cmd: 4'b0100, rn: 32'h7, rm: 32'h0};

        vecs[5].nm = "freeze_holds_sub";
        vecs[5].in = '1;
        vecs[5].in.flush = 1'b0;
        vecs[5].exp = vecs[4].exp;

        foreach (vecs[k]) begin
            step(vecs[k].in, vecs[k].nm);
            checks++;
            if (got_k !== vecs[k].exp) begin
                errors++;
                $display("FAIL %s_keys: got %h expected %h", vecs[k].nm, got_k, vecs[k].exp);
            end
        end

        // Async reset mid-cycle with nonzero contents.
        ri = '0;
        ri.valid = 1'b1; ri.wb_en = 1'b1; ri.pc = 32'h44; ri.rn = 32'h99; ri.sr = 4'hF;
        step(ri, "preload_before_reset");
        #2;
        rst_n = 1'b0;
        model = '0;
        #1;
        check_full("async_reset_midcycle");
        ri.freeze = 1'b1;
        ri.flush  = 1'b1;
        drive(ri);
        @(posedge clk);
        #1;
        check_full("reset_overrides_edge");
        rst_n = 1'b1;
        #2;
        check_full("reset_release_no_edge");

        // LDR then three freezes with changing inputs.
        ri = '0;
        ri.valid = 1'b1; ri.mem_r_en = 1'b1; ri.wb_en = 1'b1; ri.cmd = 4'b0010;
        ri.rn = 32'h2000; ri.dest = 4'd3;
        step(ri, "ldr_load");
        saved = model;
        for (int unsigned n = 0; n < 3; n++) begin
            ri = rand_in();
            ri.flush  = 1'b0;
            ri.freeze = 1'b1;
            step(ri, "ldr_freeze");
            checks++;
            if (act !== saved || exe_or_out !== 1'b1) begin
                errors++;
                $display("FAIL ldr_freeze_hold: got %h or_out=%b expected %h or_out=1", act, exe_or_out, saved);
            end
        end
        ri = '0;
        ri.valid = 1'b1; ri.mem_w_en = 1'b1; ri.rm = 32'h7777; ri.pc = 32'h80;
        step(ri, "unfreeze_load");

        // Randomized stream with occasional mid-cycle reset pulses.
        for (int unsigned c = 0; c < 10000; c++) begin
            ri = rand_in();
            step(ri, "random");
            if ($urandom_range(0, 99) == 0) begin
                #2;
                rst_n = 1'b0;
                model = '0;
                #1;
                check_full("random_reset");
                #1;
                rst_n = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
